turf_hdr_builder: RTL and testbench
===================================

// Module: turf_hdr_builder
// PURPOSE
//  Builds the 16-beat x 64-bit (128 B) TURF event header, one per accepted trigger.
//  Drives the TURF-header stream into the header accumulator (header bytes 0x00-0x7F);
//  downstream FIFO absorbs backpressure.
//  Keeps the event number and deadtime count.
//  Seals each header with an XOR check word.
// PARAMETERS
//  MAGIC      16'h5455  beat-0 marker ("TU")
//  VERSION    8'h01     header format version, beat 0
//  NBEATS     16        beats per header; fixed by downstream, must be 16
// PORTS
//  memclk          in   1   single clock; all logic synchronous to it
//  memrst          in   1   synchronous, active-high reset
//  s_trig_tdata    in   64  {trig_type[15:0], trig_time[47:0]}
//  s_trig_tuser    in   13  event buffer address
//  s_trig_tvalid   in   1   trigger valid
//  s_trig_tready   out  1   trigger accept
//  tio_mask_i      in   4   TURFIO mask, latched into header
//  busy_i          in   1   system busy; counts deadtime
//  run_reset_i     in   1   pulse: restart event numbering at 0
//  m_thdr_tdata    out  64  header beat
//  m_thdr_tvalid   out  1   header beat valid
//  m_thdr_tready   in   1   header beat accept
//  m_thdr_tlast    out  1   high on beat 15 only
//  ev_count_o      out  32  current event number (next header's number)
// BEHAVIOUR
//  Reset: state=IDLE, s_trig_tready=1, m_thdr_tvalid=0, m_thdr_tlast=0, m_thdr_tdata=0,
//   ev_count_o=0, deadtime=0, beat=0, xor=0, run_reset pending flag=0.
//  FSM, 2 states:
//   IDLE: tready=1, tvalid=0.
//    On trigger accept (tvalid&&tready): latch tdata, tuser, tio_mask_i, deadtime, ev_count;
//    beat<=0; xor<=0; go EMIT.
//   EMIT: tready=0, tvalid=1.
//    Beat accepted (tvalid&&tready): xor^=tdata; beat++.
//    Beat 15 accepted: go IDLE.
//  Latency: first beat valid the cycle after trigger accept. Back-to-back min 17 cycles/header.
//  AXIS rules: tdata/tlast stable while tvalid&&!tready; tvalid never drops before accept.
//  Beat map (bit 63 first):
//   b0  {MAGIC, VERSION, 8'h00, ev_num[31:0]}
//   b1  {16'h0, trig_time[47:0]}
//   b2  {trig_type[15:0], 12'h0, tio_mask[3:0], deadtime[31:0]}
//   b3  {51'h0, ev_addr[12:0]}
//   b4-b14  zero
//   b15 XOR of b0..b14 as emitted (from running xor; no recompute)
//  Event number:
//   +1 (mod 2^32, wraps 0xFFFFFFFF->0) on beat-15 accept.
//   run_reset_i in IDLE with no trigger accept in the same cycle: ev_count<=0 next cycle.
//   run_reset_i in EMIT, or in the same cycle as a trigger accept: set pending flag.
//    Current header keeps its latched number.
//    On beat-15 accept: ev_count<=0 (no increment), clear flag.
//  Deadtime:
//   32-bit counter, +1 each cycle busy_i=1, saturates at 0xFFFFFFFF.
//   On trigger accept, header gets the pre-clear value.
//   Counter loads 0+busy_i that same cycle, so no cycle is lost or double-counted.
//  memrst mid-header: abort immediately, outputs to reset values.
//   Partial header is not completed; downstream flushes on its own reset.
// TESTING
//  1 Reset, one trigger (time=48'h123456789ABC, type=16'h0003, addr=13'h1A5, mask=4'b0101),
//    tready=1 -> 16 beats, b0=64'h5455_0100_0000_0000, tlast on b15 only, b15=XOR(b0..b14),
//    ev_count_o=1.
//  2 Random tready stalls (50%) -> beats identical to test 1, tdata stable through stalls,
//    no extra or missing beats.
//  3 busy_i high 100 cycles, then trigger; busy held through accept ->
//    header1 b2[31:0]=100; next header counts from accept cycle (includes accept-cycle busy).
//  4 run_reset_i pulsed at beat 7 of event 5 -> that header ev_num=5, ev_count_o=0 after
//    tlast accept, next header ev_num=0.
//  5 Preload ev_count 0xFFFFFFFF (force), send header -> next ev_num=0;
//    deadtime forced to 0xFFFFFFFF stays saturated.
//  6 memrst at beat 9 -> tvalid=0 next cycle, s_trig_tready=1, ev_count_o=0.

Source files
------------

// File: rtl/turf_hdr_builder.sv
// TURF event header builder: turns each accepted trigger into a 16-beat x 64-bit header
// stream sealed with an XOR check word, and keeps the event number and deadtime count.
module turf_hdr_builder #(
  parameter logic [15:0] MAGIC   = 16'h5455,
  parameter logic [7:0]  VERSION = 8'h01,
  parameter int          NBEATS  = 16
) (
  input  logic        memclk,
  input  logic        memrst,
  input  logic [63:0] s_trig_tdata,
  input  logic [12:0] s_trig_tuser,
  input  logic        s_trig_tvalid,
  output logic        s_trig_tready,
  input  logic [3:0]  tio_mask_i,
  input  logic        busy_i,
  input  logic        run_reset_i,
  output logic [63:0] m_thdr_tdata,
  output logic        m_thdr_tvalid,
  input  logic        m_thdr_tready,
  output logic        m_thdr_tlast,
  output logic [31:0] ev_count_o,
  output logic        state_o
);

  // Both streams use AXIS valid/ready: a transfer happens on a clock edge where valid and
  // ready are both high; once valid is raised, it and the data stay put until that edge.

  localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [63:0] xor_q, xor_d;
  logic [31:0] ev_count_q, ev_count_d;
  logic [31:0] deadtime_q, deadtime_d;
  logic        pend_q, pend_d;

  logic [47:0] trig_time_q;
  logic [15:0] trig_type_q;
  logic [12:0] ev_addr_q;
  logic [3:0]  tio_mask_q;
  logic [31:0] hdr_dt_q;
  logic [31:0] hdr_ev_q;

  logic        trig_acc;
  logic        beat_acc;
  logic [63:0] beat_data;

  assign trig_acc = (state_q == IDLE) && s_trig_tvalid;
  assign beat_acc = (state_q == EMIT) && m_thdr_tready;

  always_comb begin
    beat_data = 64'h0;
    if (state_q == EMIT) begin
      case (beat_q)
        4'd0:    beat_data = {MAGIC, VERSION, 8'h00, hdr_ev_q};
        4'd1:    beat_data = {16'h0, trig_time_q};
        4'd2:    beat_data = {trig_type_q, 12'h0, tio_mask_q, hdr_dt_q};
        4'd3:    beat_data = {51'h0, ev_addr_q};
        // The check word is the running XOR of the beats actually emitted.
        LAST_BEAT: beat_data = xor_q;
        default: beat_data = 64'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    xor_d      = xor_q;
    ev_count_d = ev_count_q;
    pend_d     = pend_q;

    // The accept cycle's busy is the first count of the new interval.
    if (trig_acc) begin
      deadtime_d = {31'h0, busy_i};
    end else if (busy_i && (deadtime_q != 32'hFFFF_FFFF)) begin
      deadtime_d = deadtime_q + 32'd1;
    end else begin
      deadtime_d = deadtime_q;
    end

    case (state_q)
      IDLE: begin
        if (trig_acc) begin
          beat_d  = 4'd0;
          xor_d   = 64'h0;
          state_d = EMIT;
          if (run_reset_i) pend_d = 1'b1;
        end else if (run_reset_i) begin
          ev_count_d = 32'h0;
        end
      end
      EMIT: begin
        if (run_reset_i) pend_d = 1'b1;
        if (beat_acc) begin
          xor_d  = xor_q ^ beat_data;
          beat_d = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            if (pend_q || run_reset_i) begin
              ev_count_d = 32'h0;
              pend_d     = 1'b0;
            end else begin
              ev_count_d = ev_count_q + 32'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge memclk) begin
    if (memrst) begin
      state_q     <= IDLE;
      beat_q      <= 4'd0;
      xor_q       <= 64'h0;
      ev_count_q  <= 32'h0;
      deadtime_q  <= 32'h0;
      pend_q      <= 1'b0;
      trig_time_q <= 48'h0;
      trig_type_q <= 16'h0;
      ev_addr_q   <= 13'h0;
      tio_mask_q  <= 4'h0;
      hdr_dt_q    <= 32'h0;
      hdr_ev_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      xor_q      <= xor_d;
      ev_count_q <= ev_count_d;
      deadtime_q <= deadtime_d;
      pend_q     <= pend_d;
      if (trig_acc) begin
        trig_time_q <= s_trig_tdata[47:0];
        trig_type_q <= s_trig_tdata[63:48];
        ev_addr_q   <= s_trig_tuser;
        tio_mask_q  <= tio_mask_i;
        hdr_dt_q    <= deadtime_q;
        hdr_ev_q    <= ev_count_q;
      end
    end
  end

  assign s_trig_tready = (state_q == IDLE);
  assign m_thdr_tvalid = (state_q == EMIT);
  assign m_thdr_tlast  = (state_q == EMIT) && (beat_q == LAST_BEAT);
  assign m_thdr_tdata  = beat_data;
  assign ev_count_o    = ev_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_turf_hdr_builder.sv
// Directed bench for turf_hdr_builder: expected header beats are queued when a trigger is
// driven and compared, with tlast, as each beat is accepted on the header stream.
module tb_turf_hdr_builder;

  logic        memclk = 1'b0;
  logic        memrst;
  logic [63:0] s_trig_tdata;
  logic [12:0] s_trig_tuser;
  logic        s_trig_tvalid;
  logic        s_trig_tready;
  logic [3:0]  tio_mask_i;
  logic        busy_i;
  logic        run_reset_i;
  logic [63:0] m_thdr_tdata;
  logic        m_thdr_tvalid;
  logic        m_thdr_tready;
  logic        m_thdr_tlast;
  logic [31:0] ev_count_o;
  logic        state_o;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];
  logic        stall_en = 1'b0;

  localparam logic [47:0] T_TIME = 48'h1234_5678_9ABC;
  localparam logic [15:0] T_TYPE = 16'h0003;
  localparam logic [12:0] T_ADDR = 13'h1A5;
  localparam logic [3:0]  T_MASK = 4'b0101;

  turf_hdr_builder dut (
    .memclk        (memclk),
    .memrst        (memrst),
    .s_trig_tdata  (s_trig_tdata),
    .s_trig_tuser  (s_trig_tuser),
    .s_trig_tvalid (s_trig_tvalid),
    .s_trig_tready (s_trig_tready),
    .tio_mask_i    (tio_mask_i),
    .busy_i        (busy_i),
    .run_reset_i   (run_reset_i),
    .m_thdr_tdata  (m_thdr_tdata),
    .m_thdr_tvalid (m_thdr_tvalid),
    .m_thdr_tready (m_thdr_tready),
    .m_thdr_tlast  (m_thdr_tlast),
    .ev_count_o    (ev_count_o),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 memclk = ~memclk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int k, input logic [47:0] t,
                                           input logic [15:0] ty, input logic [12:0] a,
                                           input logic [3:0] m, input logic [31:0] dt,
                                           input logic [31:0] ev);
    case (k)
      0:       return {16'h5455, 8'h01, 8'h00, ev};
      1:       return {16'h0000, t};
      2:       return {ty, 12'h000, m, dt};
      3:       return {51'h0, a};
      default: return 64'h0;
    endcase
  endfunction

  task automatic push_hdr(input logic [31:0] dt, input logic [31:0] ev);
    logic [63:0] x;
    logic [63:0] v;
    x = 64'h0;
    for (int k = 0; k < 15; k++) begin
      v = beat_val(k, T_TIME, T_TYPE, T_ADDR, T_MASK, dt, ev);
      x = x ^ v;
      exp_q.push_back({1'b0, v});
    end
    exp_q.push_back({1'b1, x});
  endtask

  // driver tasks
  task automatic send_trig(input logic [31:0] dt, input logic [31:0] ev);
    int n;
    @(negedge memclk);
    s_trig_tdata  = {T_TYPE, T_TIME};
    s_trig_tuser  = T_ADDR;
    tio_mask_i    = T_MASK;
    s_trig_tvalid = 1'b1;
    n = 0;
    while (!s_trig_tready && n < 100) begin
      @(negedge memclk);
      n++;
    end
    check("trig_ready_wait", 65'(s_trig_tready), 65'd1);
    push_hdr(dt, ev);
    @(posedge memclk);
    #1;
    s_trig_tvalid = 1'b0;
    check("first_beat_valid", 65'(m_thdr_tvalid), 65'd1);
    check("emit_tready_low", 65'(s_trig_tready), 65'd0);
  endtask

  task automatic wait_hdr(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge memclk);
      n++;
    end
    @(posedge memclk);
    #1;
    check(tag, 65'(exp_q.size()), 65'd0);
    exp_q.delete();
  endtask

  task automatic wait_remaining(input int left);
    int n;
    n = 0;
    while (exp_q.size() > left && n < 2000) begin
      @(posedge memclk);
      n++;
    end
    check("reach_beat", 65'(exp_q.size()), 65'(left));
  endtask

  // downstream ready: random stalls when enabled
  initial begin
    m_thdr_tready = 1'b1;
    forever begin
      @(posedge memclk);
      #1;
      m_thdr_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard: compare each accepted beat, and hold data steady across stalls
  initial begin
    logic        prev_stalled;
    logic [64:0] prev_beat;
    logic [64:0] e;
    prev_stalled = 1'b0;
    prev_beat    = 65'h0;
    forever begin
      @(negedge memclk);
      if (memrst) begin
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) begin
          check("stall_valid_hold", 65'(m_thdr_tvalid), 65'd1);
          check("stall_data_hold", {m_thdr_tlast, m_thdr_tdata}, prev_beat);
        end
        if (m_thdr_tvalid && m_thdr_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", {m_thdr_tlast, m_thdr_tdata}, 65'h0_DEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_thdr_tlast, m_thdr_tdata}, e);
          end
        end
        prev_stalled = m_thdr_tvalid && !m_thdr_tready;
        prev_beat    = {m_thdr_tlast, m_thdr_tdata};
      end
    end
  end

  initial begin
    memrst        = 1'b1;
    s_trig_tdata  = 64'h0;
    s_trig_tuser  = 13'h0;
    s_trig_tvalid = 1'b0;
    tio_mask_i    = 4'h0;
    busy_i        = 1'b0;
    run_reset_i   = 1'b0;
    repeat (3) @(posedge memclk);
    #1;
    memrst = 1'b0;
    check("rst_tready", 65'(s_trig_tready), 65'd1);
    check("rst_tvalid", 65'(m_thdr_tvalid), 65'd0);
    check("rst_tlast", 65'(m_thdr_tlast), 65'd0);
    check("rst_tdata", 65'(m_thdr_tdata), 65'd0);
    check("rst_ev", 65'(ev_count_o), 65'd0);

    // 1: single header, no stalls
    send_trig(32'd0, 32'd0);
    wait_hdr("t1_done");
    check("t1_ev", 65'(ev_count_o), 65'd1);

    // 2: random downstream stalls
    stall_en = 1'b1;
    send_trig(32'd0, 32'd1);
    wait_hdr("t2_done");
    stall_en = 1'b0;
    check("t2_ev", 65'(ev_count_o), 65'd2);

    // 3: 100 busy cycles, busy also high in the accept cycle
    @(negedge memclk);
    busy_i = 1'b1;
    repeat (100) @(posedge memclk);
    send_trig(32'd100, 32'd2);
    busy_i = 1'b0;
    wait_hdr("t3_done_a");
    send_trig(32'd1, 32'd3);
    wait_hdr("t3_done_b");
    check("t3_ev", 65'(ev_count_o), 65'd4);

    // 4: run_reset mid-header, then in IDLE
    send_trig(32'd0, 32'd4);
    wait_hdr("t4_done_a");
    send_trig(32'd0, 32'd5);
    wait_remaining(8);
    #1;
    run_reset_i = 1'b1;
    @(posedge memclk);
    #1;
    run_reset_i = 1'b0;
    check("t4_ev_kept_mid", 65'(ev_count_o), 65'd5);
    wait_hdr("t4_done_b");
    check("t4_ev_cleared", 65'(ev_count_o), 65'd0);
    send_trig(32'd0, 32'd0);
    wait_hdr("t4_done_c");
    check("t4_ev_after", 65'(ev_count_o), 65'd1);
    @(negedge memclk);
    run_reset_i = 1'b1;
    @(posedge memclk);
    #1;
    run_reset_i = 1'b0;
    check("t4_idle_run_reset", 65'(ev_count_o), 65'd0);

    // 5: event number wrap and deadtime saturation
    @(negedge memclk);
    force dut.ev_count_q = 32'hFFFF_FFFF;
    force dut.deadtime_q = 32'hFFFF_FFFF;
    busy_i = 1'b1;
    @(posedge memclk);
    #1;
    release dut.ev_count_q;
    release dut.deadtime_q;
    repeat (5) @(posedge memclk);
    #1;
    check("t5_ev_preload", 65'(ev_count_o), 65'hFFFF_FFFF);
    send_trig(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_i = 1'b0;
    wait_hdr("t5_done_a");
    check("t5_ev_wrap", 65'(ev_count_o), 65'd0);
    send_trig(32'd1, 32'd0);
    wait_hdr("t5_done_b");
    check("t5_ev_after", 65'(ev_count_o), 65'd1);

    // 6: reset in the middle of a header
    send_trig(32'd0, 32'd1);
    wait_remaining(6);
    #1;
    memrst = 1'b1;
    exp_q.delete();
    @(posedge memclk);
    #1;
    memrst = 1'b0;
    check("t6_tvalid", 65'(m_thdr_tvalid), 65'd0);
    check("t6_tready", 65'(s_trig_tready), 65'd1);
    check("t6_tlast", 65'(m_thdr_tlast), 65'd0);
    check("t6_ev", 65'(ev_count_o), 65'd0);
    send_trig(32'd0, 32'd0);
    wait_hdr("t6_recover");
    check("t6_ev_after", 65'(ev_count_o), 65'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
